// File: rtl/grid_port_arbiter.sv
// grid_port_arbiter: shares the single-port grid BRAM between pusher,
// scatterer and solver with round-robin grant, RMW lock and read tagging.
module grid_port_arbiter #(
   parameter int ADDR_W   = 14,
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 2,
   parameter int LOCK_MAX = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2:0]          phase_mask,
   input  logic [2:0]          req_valid,
   output logic [2:0]          req_ready,
   input  logic [2:0]          req_we,
   input  logic [2:0]          req_lock,
   input  logic [3*ADDR_W-1:0] req_addr,
   input  logic [3*DATA_W-1:0] req_wdata,
   output logic [2:0]          rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy,
   output logic                lock_err
);

   localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
   localparam int TAG_D = READ_LAT + 1;

   typedef enum logic {
      LK_FREE = 1'b0,
      LK_HELD = 1'b1
   } lk_state_t;

   lk_state_t         r_lk_state;
   lk_state_t         w_lk_next;
   logic [1:0]        r_lock_owner;
   logic [1:0]        w_owner_next;
   logic [CNT_W-1:0]  r_lock_cnt;
   logic [CNT_W-1:0]  w_cnt_next;
   logic              r_lock_err;
   logic              w_err_next;
   logic              w_lock_held;
   logic [2:0]        w_owner_mask;

   logic [1:0]        r_rr_ptr;
   logic [1:0]        w_ord0;
   logic [1:0]        w_ord1;
   logic [1:0]        w_ord2;
   logic [2:0]        w_elig;
   logic [2:0]        w_grant;
   logic [1:0]        w_gidx;
   logic              w_hs;
   logic              w_g_we;
   logic              w_g_lock;
   logic [ADDR_W-1:0] w_g_addr;
   logic [DATA_W-1:0] w_g_wdata;

   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;

   logic [TAG_D-1:0]       r_tag_v;
   logic [TAG_D-1:0][1:0]  r_tag_o;

   // Lock FSM: state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lk_state   <= LK_FREE;
         r_lock_owner <= 2'd0;
         r_lock_cnt   <= '0;
         r_lock_err   <= 1'b0;
      end else begin
         r_lk_state   <= w_lk_next;
         r_lock_owner <= w_owner_next;
         r_lock_cnt   <= w_cnt_next;
         r_lock_err   <= w_err_next;
      end
   end

   // Lock FSM: next state
   always_comb begin
      w_lk_next    = r_lk_state;
      w_owner_next = r_lock_owner;
      w_cnt_next   = r_lock_cnt;
      w_err_next   = r_lock_err;
      unique case (r_lk_state)
         LK_FREE: begin
            if (w_hs && w_g_lock) begin
               w_lk_next    = LK_HELD;
               w_owner_next = w_gidx;
               w_cnt_next   = '0;
            end
         end
         LK_HELD: begin
            if (w_hs && w_g_lock) begin
               w_owner_next = w_gidx;
               w_cnt_next   = '0;
            end else if (w_hs) begin
               w_lk_next = LK_FREE;
            end else if (r_lock_cnt == CNT_LAST) begin
               w_lk_next  = LK_FREE;
               w_err_next = 1'b1;
            end else begin
               w_cnt_next = r_lock_cnt + CNT_W'(1);
            end
         end
      endcase
   end

   // Lock FSM: outputs
   always_comb begin
      w_lock_held  = 1'b0;
      w_owner_mask = 3'b000;
      unique case (r_lk_state)
         LK_FREE: begin
            w_lock_held = 1'b0;
         end
         LK_HELD: begin
            w_lock_held  = 1'b1;
            w_owner_mask = 3'b001 << r_lock_owner;
         end
      endcase
   end

   // Gated by rst so every output reads 0 while reset is asserted
   assign w_elig = (w_lock_held ? (req_valid & w_owner_mask)
                                : (req_valid & phase_mask))
                   & {3{rst}};

   always_comb begin
      w_ord0 = 2'd0;
      w_ord1 = 2'd1;
      w_ord2 = 2'd2;
      unique case (r_rr_ptr)
         2'd0: begin
            w_ord0 = 2'd1;
            w_ord1 = 2'd2;
            w_ord2 = 2'd0;
         end
         2'd1: begin
            w_ord0 = 2'd2;
            w_ord1 = 2'd0;
            w_ord2 = 2'd1;
         end
         default: begin
            w_ord0 = 2'd0;
            w_ord1 = 2'd1;
            w_ord2 = 2'd2;
         end
      endcase
   end

   always_comb begin
      w_gidx = w_ord0;
      w_hs   = 1'b1;
      if (w_elig[w_ord0]) begin
         w_gidx = w_ord0;
      end else if (w_elig[w_ord1]) begin
         w_gidx = w_ord1;
      end else if (w_elig[w_ord2]) begin
         w_gidx = w_ord2;
      end else begin
         w_hs = 1'b0;
      end
   end

   assign w_grant   = w_hs ? (3'b001 << w_gidx) : 3'b000;
   assign w_g_we    = req_we[w_gidx];
   assign w_g_lock  = req_lock[w_gidx];
   assign w_g_addr  = req_addr[32'(w_gidx) * ADDR_W +: ADDR_W];
   assign w_g_wdata = req_wdata[32'(w_gidx) * DATA_W +: DATA_W];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rr_ptr    <= 2'd2;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_mem_en <= w_hs;
         r_mem_we <= w_hs & w_g_we;
         if (w_hs) begin
            r_rr_ptr    <= w_gidx;
            r_mem_addr  <= w_g_addr;
            r_mem_wdata <= w_g_wdata;
         end
      end
   end

   // Tag stage k is visible k+1 cycles after the read handshake
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tag_v <= '0;
         r_tag_o <= '0;
      end else begin
         r_tag_v[0] <= w_hs & ~w_g_we;
         r_tag_o[0] <= w_gidx;
         for (int k = 1; k < TAG_D; k++) begin
            r_tag_v[k] <= r_tag_v[k-1];
            r_tag_o[k] <= r_tag_o[k-1];
         end
      end
   end

   assign req_ready = w_grant;
   assign rsp_valid = r_tag_v[TAG_D-1] ? (3'b001 << r_tag_o[TAG_D-1])
                                       : 3'b000;
   assign rsp_rdata = r_tag_v[TAG_D-1] ? mem_rdata : '0;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign busy      = (|r_tag_v) | w_lock_held | (|w_elig);
   assign lock_err  = r_lock_err;

endmodule
